// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared opcodes and loop-controller state type for the brainfuck core
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        SCAN_ADDR,
        SCAN_CHK,
        HALT
    } loop_state_t;

    function automatic logic is_loop_op(input logic [7:0] op);
        return (op == OP_OPEN) || (op == OP_CLOSE);
    endfunction

endpackage

// File: rtl/bf_return_stack.sv
// rtl/bf_return_stack.sv - LIFO of return addresses for open loops
module bf_return_stack #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_count;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_wr_idx  = r_count[PW-1:0];
    assign w_top_idx = w_wr_idx - 1'b1;
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_top     = r_mem[w_top_idx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Contents need no reset: the count alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/bf_loop_controller.sv
// rtl/bf_loop_controller.sv - executes '[' and ']' by redirecting the core pc and scanning code RAM
module bf_loop_controller
    import bf_pkg::*;
#(
    parameter int addrSize   = 9,
    parameter int stackDepth = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data_code,
    input  logic [addrSize-1:0] pc,
    input  logic                cell_zero,
    output logic                hold,
    output logic                code_sel,
    output logic [addrSize-1:0] scan_addr,
    output logic                pc_load,
    output logic [addrSize-1:0] pc_value,
    output logic                err_overflow,
    output logic                err_underflow,
    output logic                err_unmatched
);

    localparam logic [addrSize-1:0] ONE = addrSize'(1);

    loop_state_t         r_state;
    logic                r_is_close;
    logic [addrSize-1:0] r_depth;
    logic                r_hold;
    logic                r_code_sel;
    logic [addrSize-1:0] r_scan_addr;
    logic                r_pc_load;
    logic [addrSize-1:0] r_pc_value;
    logic                r_err_overflow;
    logic                r_err_underflow;
    logic                r_err_unmatched;

    logic [addrSize-1:0] w_top;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_push = (r_state == DECIDE) && !r_is_close && !cell_zero && !w_full;
    assign w_pop  = (r_state == DECIDE) && r_is_close && cell_zero && !w_empty;

    bf_return_stack #(
        .WIDTH (addrSize),
        .DEPTH (stackDepth)
    ) u_stack (
        .clk     (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (pc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_is_close      <= 1'b0;
            r_depth         <= '0;
            r_hold          <= 1'b0;
            r_code_sel      <= 1'b0;
            r_scan_addr     <= '0;
            r_pc_load       <= 1'b0;
            r_pc_value      <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_unmatched <= 1'b0;
        end else begin
            r_pc_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    // hold is still high only in the pc_load cycle; data_code is stale then.
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else if (is_loop_op(data_code)) begin
                        r_hold     <= 1'b1;
                        r_is_close <= (data_code == OP_CLOSE);
                        r_state    <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (!r_is_close) begin
                        if (cell_zero) begin
                            r_depth     <= ONE;
                            r_scan_addr <= pc + ONE;
                            r_code_sel  <= 1'b1;
                            r_state     <= SCAN_ADDR;
                        end else if (w_full) begin
                            r_err_overflow <= 1'b1;
                            r_state        <= HALT;
                        end else begin
                            r_pc_value <= pc + ONE;
                            r_pc_load  <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end else if (w_empty) begin
                        r_err_underflow <= 1'b1;
                        r_state         <= HALT;
                    end else begin
                        r_pc_value <= cell_zero ? (pc + ONE) : (w_top + ONE);
                        r_pc_load  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                SCAN_ADDR: begin
                    r_state <= SCAN_CHK;
                end
                SCAN_CHK: begin
                    if ((data_code == OP_CLOSE) && (r_depth == ONE)) begin
                        r_pc_value <= r_scan_addr + ONE;
                        r_pc_load  <= 1'b1;
                        r_code_sel <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        if (data_code == OP_OPEN) begin
                            r_depth <= r_depth + ONE;
                        end else if (data_code == OP_CLOSE) begin
                            r_depth <= r_depth - ONE;
                        end
                        if (r_scan_addr == '1) begin
                            r_err_unmatched <= 1'b1;
                            r_code_sel      <= 1'b0;
                            r_state         <= HALT;
                        end else begin
                            r_scan_addr <= r_scan_addr + ONE;
                            r_state     <= SCAN_ADDR;
                        end
                    end
                end
                HALT: begin
                    r_hold <= 1'b1;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign hold          = r_hold;
    assign code_sel      = r_code_sel;
    assign scan_addr     = r_scan_addr;
    assign pc_load       = r_pc_load;
    assign pc_value      = r_pc_value;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;
    assign err_unmatched = r_err_unmatched;

endmodule

// File: tb/tb_bf_loop_controller.sv
// tb/tb_bf_loop_controller.sv - randomized self-checking bench for bf_loop_controller
module tb_bf_loop_controller;
    import bf_pkg::*;

    localparam int AW = 9;
    localparam int TOP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    data_code;
    logic [AW-1:0] pc = '0;
    logic          cell_zero = 1'b0;
    logic          hold;
    logic          code_sel;
    logic [AW-1:0] scan_addr;
    logic          pc_load;
    logic [AW-1:0] pc_value;
    logic          err_overflow;
    logic          err_underflow;
    logic          err_unmatched;

    logic [7:0] mem [1 << AW];
    logic [7:0] ram_q = 8'h00;
    logic [7:0] drv_op = OP_INC;
    logic       scan_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[scan_addr];
    assign data_code = scan_mode ? ram_q : drv_op;

    bf_loop_controller #(.addrSize(AW), .stackDepth(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_code     (data_code),
        .pc            (pc),
        .cell_zero     (cell_zero),
        .hold          (hold),
        .code_sel      (code_sel),
        .scan_addr     (scan_addr),
        .pc_load       (pc_load),
        .pc_value      (pc_value),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_unmatched (err_unmatched)
    );

    // Matching ']' by bracket counting; -1 when the top address is passed first.
    function automatic int find_match(input int p);
        int d = 1;
        for (int a = p + 1; a <= TOP; a++) begin
            if (mem[a] == OP_OPEN) d++;
            else if (mem[a] == OP_CLOSE) begin
                d--;
                if (d == 0) return a;
            end
        end
        return -1;
    endfunction

    task automatic fill_mem(input logic [7:0] v);
        for (int a = 0; a <= TOP; a++) mem[a] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        scan_mode = 1'b0;
        drv_op = OP_INC;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Plays the core: presents one opcode, then watches until pc_load, an error, or timeout.
    task automatic exec(input logic [7:0] op, input int p, input logic cz, input logic scan,
                        output logic got, output int val, output int cyc, output int hcnt,
                        output logic cs_at_load, output logic again);
        @(negedge clk);
        scan_mode = 1'b0;
        drv_op = op;
        pc = AW'(p);
        cell_zero = cz;
        got = 0; val = 0; cyc = 0; hcnt = 0; cs_at_load = 0; again = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (i == 1) begin
                drv_op = OP_INC;
                scan_mode = scan;
            end
            if (hold) hcnt++;
            if (pc_load) begin
                got = 1;
                val = int'(pc_value);
                cyc = i;
                cs_at_load = code_sel;
                scan_mode = 1'b0;
                @(negedge clk);
                if (hold) hcnt++;
                again = pc_load;
                break;
            end
            if (err_overflow || err_underflow || err_unmatched) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({hold, code_sel, scan_addr, pc_load, pc_value, err_overflow, err_underflow, err_unmatched} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got hold=%b sel=%b scan=%0d load=%b val=%0d err=%b%b%b want all 0",
                     hold, code_sel, scan_addr, pc_load, pc_value, err_overflow, err_underflow, err_unmatched);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_open_close();
        logic g, cs, ag; int v, c, h;
        do_reset();
        exec(OP_OPEN, 5, 1'b0, 1'b0, g, v, c, h, cs, ag);
        checks++;
        if (!(g && v == 6 && c == 2 && h == 2 && !ag)) begin
            failures++;
            $display("FAIL open_push got load=%b val=%0d cyc=%0d hold=%0d again=%b want 1 6 2 2 0", g, v, c, h, ag);
        end
        for (int k = 0; k < 2; k++) begin
            exec(OP_CLOSE, 9, 1'b0, 1'b0, g, v, c, h, cs, ag);
            checks++;
            if (!(g && v == 6 && h == 2)) begin
                failures++;
                $display("FAIL close_loop_back%0d got load=%b val=%0d hold=%0d want 1 6 2", k, g, v, h);
            end
        end
        exec(OP_CLOSE, 9, 1'b1, 1'b0, g, v, c, h, cs, ag);
        checks++;
        if (!(g && v == 10 && h == 2)) begin
            failures++;
            $display("FAIL close_exit got load=%b val=%0d hold=%0d want 1 10 2", g, v, h);
        end
        exec(OP_CLOSE, 9, 1'b1, 1'b0, g, v, c, h, cs, ag);
        checks++;
        if (!(!g && err_underflow && hold)) begin
            failures++;
            $display("FAIL stack_empty_after_pop got load=%b underflow=%b hold=%b want 0 1 1", g, err_underflow, hold);
        end
    endtask

    task automatic test_wrap();
        logic g, cs, ag; int v, c, h;
        do_reset();
        exec(OP_OPEN, TOP, 1'b0, 1'b0, g, v, c, h, cs, ag);
        exec(OP_CLOSE, 100, 1'b0, 1'b0, g, v, c, h, cs, ag);
        checks++;
        if (!(g && v == 0)) begin
            failures++;
            $display("FAIL top_plus_one_wrap got load=%b val=%0d want 1 0", g, v);
        end
    endtask

    task automatic test_scan();
        logic g, cs, ag; int v, c, h;
        logic [7:0] prog [8];
        prog = '{OP_OPEN, OP_INC, OP_OPEN, OP_DEC, OP_CLOSE, OP_RIGHT, OP_CLOSE, OP_INC};
        do_reset();
        fill_mem(OP_INC);
        for (int a = 0; a < 8; a++) mem[a] = prog[a];
        exec(OP_OPEN, 0, 1'b1, 1'b1, g, v, c, h, cs, ag);
        checks++;
        if (!(g && v == 7 && c == 14 && h == 14 && !cs && !ag)) begin
            failures++;
            $display("FAIL scan_forward got load=%b val=%0d cyc=%0d hold=%0d sel=%b want 1 7 14 14 0", g, v, c, h, cs);
        end
    endtask

    task automatic test_overflow();
        logic g, cs, ag; int v, c, h; int loads = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exec(OP_OPEN, k, 1'b0, 1'b0, g, v, c, h, cs, ag);
            if (g && v == k + 1) loads++;
        end
        checks++;
        if (loads != 8 || err_overflow) begin
            failures++;
            $display("FAIL eight_pushes got loads=%0d overflow=%b want 8 0", loads, err_overflow);
        end
        exec(OP_OPEN, 8, 1'b0, 1'b0, g, v, c, h, cs, ag);
        repeat (3) @(negedge clk);
        checks++;
        if (!(!g && err_overflow && hold && !pc_load)) begin
            failures++;
            $display("FAIL overflow got load=%b overflow=%b hold=%b want 0 1 1", g, err_overflow, hold);
        end
    endtask

    task automatic test_underflow();
        logic g, cs, ag; int v, c, h;
        do_reset();
        exec(OP_CLOSE, 3, 1'b0, 1'b0, g, v, c, h, cs, ag);
        repeat (3) @(negedge clk);
        checks++;
        if (!(!g && err_underflow && hold && !err_overflow)) begin
            failures++;
            $display("FAIL underflow got load=%b underflow=%b hold=%b want 0 1 1", g, err_underflow, hold);
        end
    endtask

    task automatic test_unmatched();
        logic g, cs, ag; int v, c, h;
        do_reset();
        fill_mem(8'h00);
        mem[0] = OP_OPEN; mem[1] = OP_INC; mem[2] = OP_INC;
        exec(OP_OPEN, 0, 1'b1, 1'b1, g, v, c, h, cs, ag);
        checks++;
        if (!(!g && err_unmatched && c == 2 + 2 * TOP && scan_addr == AW'(TOP) && hold)) begin
            failures++;
            $display("FAIL unmatched got load=%b unmatched=%b cyc=%0d scan=%0d hold=%b want 0 1 %0d %0d 1",
                     g, err_unmatched, c, scan_addr, hold, 2 + 2 * TOP, TOP);
        end
        scan_mode = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        logic g, cs, ag; int v, c, h;
        do_reset();
        fill_mem(OP_INC);
        mem[0] = OP_OPEN; mem[6] = OP_CLOSE;
        @(negedge clk);
        drv_op = OP_OPEN; pc = '0; cell_zero = 1'b1;
        @(negedge clk);
        drv_op = OP_INC; scan_mode = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (!(code_sel && hold)) begin
            failures++;
            $display("FAIL scan_in_progress got sel=%b hold=%b want 1 1", code_sel, hold);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hold, code_sel, scan_addr, pc_load, pc_value, err_overflow, err_underflow, err_unmatched} !== '0) begin
            failures++;
            $display("FAIL async_reset got hold=%b sel=%b scan=%0d load=%b val=%0d want all 0",
                     hold, code_sel, scan_addr, pc_load, pc_value);
        end
        @(negedge clk);
        scan_mode = 1'b0;
        reset = 1'b1;
        exec(OP_OPEN, 20, 1'b0, 1'b0, g, v, c, h, cs, ag);
        exec(OP_CLOSE, 30, 1'b0, 1'b0, g, v, c, h, cs, ag);
        checks++;
        if (!(g && v == 21)) begin
            failures++;
            $display("FAIL push_after_reset got load=%b val=%0d want 1 21", g, v);
        end
        exec(OP_CLOSE, 30, 1'b1, 1'b0, g, v, c, h, cs, ag);
        exec(OP_CLOSE, 30, 1'b1, 1'b0, g, v, c, h, cs, ag);
        checks++;
        if (!(!g && err_underflow)) begin
            failures++;
            $display("FAIL single_entry_after_reset got load=%b underflow=%b want 0 1", g, err_underflow);
        end
    endtask

    task automatic test_random_stack();
        logic g, cs, ag; int v, c, h;
        int stk[$];
        int p, expv;
        logic is_close, cz;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            p = $urandom_range(0, TOP);
            if (stk.size() == 0) is_close = 0;
            else if (stk.size() == 8) is_close = 1;
            else is_close = $urandom_range(0, 1);
            cz = is_close ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!is_close) begin
                stk.push_back(p);
                expv = (p + 1) % (TOP + 1);
            end else if (!cz) begin
                expv = (stk[$] + 1) % (TOP + 1);
            end else begin
                void'(stk.pop_back());
                expv = (p + 1) % (TOP + 1);
            end
            exec(is_close ? OP_CLOSE : OP_OPEN, p, cz, 1'b0, g, v, c, h, cs, ag);
            checks++;
            if (!(g && v == expv && c == 2 && h == 2 && !ag)) begin
                failures++;
                $display("FAIL rand_stack%0d got load=%b val=%0d cyc=%0d hold=%0d again=%b want 1 %0d 2 2 0",
                         it, g, v, c, h, ag, expv);
            end
        end
    endtask

    task automatic test_random_scan();
        logic g, cs, ag; int v, c, h;
        int p, m, r;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int a = 0; a <= TOP; a++) begin
                r = $urandom_range(0, 9);
                mem[a] = (r < 2) ? OP_OPEN : (r < 4) ? OP_CLOSE : (r < 7) ? OP_INC : OP_LEFT;
            end
            p = $urandom_range(0, 400);
            mem[p] = OP_OPEN;
            m = find_match(p);
            exec(OP_OPEN, p, 1'b1, 1'b1, g, v, c, h, cs, ag);
            checks++;
            if (m >= 0) begin
                if (!(g && v == m + 1 && c == 2 + 2 * (m - p) && h == c && !cs)) begin
                    failures++;
                    $display("FAIL rand_scan%0d got load=%b val=%0d cyc=%0d want 1 %0d %0d", it, g, v, c, m + 1, 2 + 2 * (m - p));
                end
            end else if (!(!g && err_unmatched && c == 2 + 2 * (TOP - p))) begin
                failures++;
                $display("FAIL rand_scan%0d got load=%b unmatched=%b cyc=%0d want 0 1 %0d", it, g, err_unmatched, c, 2 + 2 * (TOP - p));
            end
            scan_mode = 1'b0;
        end
    endtask

    initial begin
        fill_mem(OP_INC);
        test_reset();
        test_open_close();
        test_wrap();
        test_scan();
        test_overflow();
        test_underflow();
        test_unmatched();
        test_reset_mid_scan();
        test_random_stack();
        test_random_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
